fetch_sched: RTL and testbench

Instruction-fetch scheduler for the pipelined MIPS core: owns the program counter, drives the word address of the synchronous-read-free instruction ROM, and buffers fetched instructions in a small FIFO in front of the decode stage. Decode consumes through a valid/ready handshake. Execute-stage branch/jump resolution redirects fetch and flushes the buffer, replacing the PC/stall/npc logic currently embedded in the fetch memory.

---
 rtl/fetch_sched.sv | 155 +++++++++++++++
 tb/tb_fetch_sched.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_sched.sv
// fetch_sched: instruction-fetch scheduler for the pipelined MIPS core.
// Owns the PC, drives the instruction-ROM word address and buffers fetched
// {pc, instr} pairs in a DEPTH-entry circular FIFO in front of decode.
// Optional feature macro: FETCH_ADDR_CHECK_EN (fetch address fault + HALT).
module fetch_sched #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter int unsigned ROM_WORDS = 1024,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [$clog2(ROM_WORDS)-1:0] rom_addr,
    input  logic [31:0]                  rom_data,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    input  logic                         id_ready,
    output logic                         id_valid,
    output logic [31:0]                  id_instr,
    output logic [31:0]                  id_pc,
    output logic [31:0]                  id_pc8,
    output logic                         fault
);

    localparam int unsigned AW = $clog2(ROM_WORDS);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            fault_q, fault_d;
    logic [31:0]     buf_pc_q    [DEPTH];
    logic [31:0]     buf_pc_d    [DEPTH];
    logic [31:0]     buf_instr_q [DEPTH];
    logic [31:0]     buf_instr_d [DEPTH];

    logic            run;
    logic            flush;
    logic            pop;
    logic            push;
    logic            bad_pc;
    logic [31:0]     pc_off;

    // Pointer advance with wrap modulo DEPTH (DEPTH need not be a power of two)
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pc_off   = pc_q - PC_RESET;
    assign rom_addr = pc_off[AW+1:2];

`ifdef FETCH_ADDR_CHECK_EN
    assign bad_pc = (pc_q[1:0] != 2'b00) |
                    ({1'b0, pc_off} >= (33'(ROM_WORDS) << 2));
    assign fault  = fault_q;
`else
    logic unused_pc_bits;
    assign bad_pc         = 1'b0;
    assign fault          = 1'b0;
    assign unused_pc_bits = ^{pc_off[31:AW+2], pc_off[1:0], fault_q};
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    // FSM next state: only an address fault in RUN (without redirect) halts
    always_comb begin
        state_d = state_q;
        if (state_q == RUN && !redirect && bad_pc) state_d = HALT;
    end

    // FSM outputs: fetch activity is enabled only in RUN
    always_comb begin
        run = (state_q == RUN);
    end

    // Handshake and fetch qualifiers; redirect in HALT is ignored
    always_comb begin
        id_valid = (count_q != '0);
        pop      = id_valid & id_ready;
        flush    = run & redirect;
        push     = run & ~redirect & ((count_q < CW'(DEPTH)) | pop) & ~bad_pc;
    end

    // Next-state for PC, pointers, count, sticky fault and buffer contents
    always_comb begin
        pc_d        = pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        fault_d     = fault_q | (run & ~redirect & bad_pc);
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        if (flush) begin
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                buf_pc_d[wr_ptr_q]    = pc_q;
                buf_instr_d[wr_ptr_q] = rom_data;
                wr_ptr_d              = ptr_inc(wr_ptr_q);
                pc_d                  = pc_q + 32'd4;
            end
            if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= PC_RESET;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            fault_q  <= fault_d;
        end
    end

    // Buffer storage; contents are only observed through the valid-gated head
    always_ff @(posedge clk) begin
        buf_pc_q    <= buf_pc_d;
        buf_instr_q <= buf_instr_d;
    end

    // Head-entry outputs, forced to 0/0/8 while empty so reset values are defined
    always_comb begin
        id_pc    = id_valid ? buf_pc_q[rd_ptr_q]    : '0;
        id_instr = id_valid ? buf_instr_q[rd_ptr_q] : '0;
        id_pc8   = id_pc + 32'd8;
    end

endmodule

// File: tb/tb_fetch_sched.sv
// Directed self-checking bench for fetch_sched (DEPTH=2, ROM_WORDS=1024).
// The ROM model returns 32'hC0DE_0000 | word_index, so expected instruction
// words follow directly from the expected fetch address.
module tb_fetch_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic        fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rom_data = 32'hC0DE_0000 | {22'd0, rom_addr};

    fetch_sched #(
        .PC_RESET  (32'h0000_3000),
        .ROM_WORDS (1024),
        .DEPTH     (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc8      (id_pc8),
        .fault       (fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
        chk({tag, "_pc"}, id_pc, pc);
        chk({tag, "_pc8"}, id_pc8, pc + 32'd8);
        chk({tag, "_instr"}, id_instr, 32'hC0DE_0000 | ((pc - 32'h3000) >> 2) & 32'h3FF);
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b1;

        // Reset for two cycles
        tick();
        tick();
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_addr", {22'd0, rom_addr}, 32'd0);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_instr", id_instr, 32'd0);
        chk("rst_pc8", id_pc8, 32'd8);

        // Streaming with id_ready high: one instruction per cycle
        reset = 1'b0;
        tick();
        chk_head("s0", 32'h3000);
        chk("s0_addr", {22'd0, rom_addr}, 32'd1);
        tick();
        chk_head("s1", 32'h3004);
        tick();
        chk_head("s2", 32'h3008);

        // Decode stall from the first fetch onward: buffer fills, PC holds
        reset    = 1'b1;
        id_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall%0d", i), id_pc, 32'h3000);
            if (i >= 1) chk($sformatf("stall_addr%0d", i), {22'd0, rom_addr}, 32'd2);
        end
        chk("stall_instr", id_instr, 32'hC0DE_0000);
        id_ready = 1'b1;
        #1;
        chk_head("rel0", 32'h3000);
        tick();
        chk_head("rel1", 32'h3004);
        tick();
        chk_head("rel2", 32'h3008);

        // Redirect while full (push+pop keeps count at DEPTH)
        redirect    = 1'b1;
        redirect_pc = 32'h3100;
        tick();
        redirect = 1'b0;
        chk("redir_valid", {31'd0, id_valid}, 32'd0);
        chk("redir_addr", {22'd0, rom_addr}, 32'h40);
        tick();
        chk_head("redir_tgt", 32'h3100);

        // Fill with decode stalled, then reset mid-stall
        id_ready = 1'b0;
        tick();
        chk("fill_addr", {22'd0, rom_addr}, 32'h42);
        chk("fill_pc", id_pc, 32'h3100);
        reset = 1'b1;
        tick();
        chk("rstfull_valid", {31'd0, id_valid}, 32'd0);
        chk("rstfull_fault", {31'd0, fault}, 32'd0);
        reset = 1'b0;
        tick();
        chk_head("rstfull_first", 32'h3000);
        id_ready = 1'b1;

`ifdef FETCH_ADDR_CHECK_EN
        // Misaligned redirect target faults and halts
        redirect    = 1'b1;
        redirect_pc = 32'h3002;
        tick();
        redirect = 1'b0;
        chk("mis_valid0", {31'd0, id_valid}, 32'd0);
        chk("mis_fault0", {31'd0, fault}, 32'd0);
        tick();
        chk("mis_fault1", {31'd0, fault}, 32'd1);
        chk("mis_valid1", {31'd0, id_valid}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h3000;
        tick();
        redirect = 1'b0;
        tick();
        chk("halt_valid", {31'd0, id_valid}, 32'd0);
        chk("halt_fault", {31'd0, fault}, 32'd1);

        // Out-of-range redirect target faults the same way
        reset = 1'b1;
        tick();
        chk("oor_rst_fault", {31'd0, fault}, 32'd0);
        reset       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h4000;
        tick();
        redirect = 1'b0;
        chk("oor_valid0", {31'd0, id_valid}, 32'd0);
        tick();
        chk("oor_fault", {31'd0, fault}, 32'd1);
        chk("oor_valid1", {31'd0, id_valid}, 32'd0);
        tick();
        chk("oor_valid2", {31'd0, id_valid}, 32'd0);
`else
        // Without address checking the ROM index simply wraps
        redirect    = 1'b1;
        redirect_pc = 32'h4004;
        tick();
        redirect = 1'b0;
        chk("wrap_valid0", {31'd0, id_valid}, 32'd0);
        chk("wrap_addr", {22'd0, rom_addr}, 32'd1);
        tick();
        chk("wrap_pc", id_pc, 32'h4004);
        chk("wrap_instr", id_instr, 32'hC0DE_0001);
        chk("wrap_pc8", id_pc8, 32'h400C);
        chk("wrap_fault", {31'd0, fault}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
